// File: rtl/fifo_byte_serializer.sv
// Pulls one word at a time from a synchronous FIFO and streams it out as bytes with a valid/ready handshake.
// Define FIFO_SER_MSB_FIRST_EN to send the most-significant byte first; by default the least-significant byte goes first.
module fifo_byte_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int BEATS = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t                state_reg;
  logic                  rd_en_reg;
  logic                  valid_reg;
  logic                  last_reg;
  logic [7:0]            data_reg;
  logic                  busy_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [DATA_WIDTH-1:0] shift_reg;

  logic [7:0]            first_byte;
  logic [7:0]            next_byte;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [IDX_W-1:0]      idx_next;

  // The byte currently on m_data always sits at the outgoing end of shift_reg.
`ifdef FIFO_SER_MSB_FIRST_EN
  assign first_byte = fifo_data[DATA_WIDTH-1 -: 8];
  assign next_byte  = shift_reg[DATA_WIDTH-9 -: 8];
  assign shift_next = shift_reg << 8;
`else
  assign first_byte = fifo_data[7:0];
  assign next_byte  = shift_reg[15:8];
  assign shift_next = shift_reg >> 8;
`endif

  assign idx_next = idx_reg + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rd_en_reg <= 1'b0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      data_reg  <= 8'h00;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_reg <= READ;
            rd_en_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        READ: begin
          rd_en_reg <= 1'b0;
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          // FIFO read data is valid now, one cycle after the read strobe.
          shift_reg <= fifo_data;
          idx_reg   <= '0;
          data_reg  <= first_byte;
          last_reg  <= 1'b0;
          valid_reg <= 1'b1;
          state_reg <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            if (idx_reg == LAST_IDX) begin
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
              idx_reg   <= '0;
              cnt_reg   <= cnt_reg + CNT_WIDTH'(1);
              // Chain straight into the next read so consecutive words leave no gap.
              if (!fifo_empty) begin
                state_reg <= READ;
                rd_en_reg <= 1'b1;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              idx_reg   <= idx_next;
              shift_reg <= shift_next;
              data_reg  <= next_byte;
              last_reg  <= (idx_next == LAST_IDX);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          rd_en_reg <= 1'b0;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_reg;
  assign m_valid    = valid_reg;
  assign m_data     = data_reg;
  assign m_last     = last_reg;
  assign busy       = busy_reg;
  assign word_cnt   = cnt_reg;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: a byte-queue model fed from a small FIFO model, plus directed literal checks.
// Honours FIFO_SER_MSB_FIRST_EN for the expected byte order.
module tb_fifo_byte_serializer;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int BEATS = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [7:0]    m_data;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] word_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fifo_byte_serializer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO model: data appears the cycle after the read strobe.
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
    end
  endtask

  // Model: every word leaving the FIFO becomes BEATS bytes in order; a reset drops whatever is queued.
  logic [7:0] exp_q[$];
  int exp_beat = 0;
  int exp_cnt = 0;
  bit chk_en = 1'b0;
  int rd_cyc[$];
  int xfer_cyc[$];
  int last_cyc[$];
  logic [7:0] xfer_byte[$];

  always @(negedge clk) begin
    logic [DW-1:0] w;
    if (chk_en) begin
      chk("word_cnt", 32'(word_cnt), 32'(exp_cnt % (1 << CW)));
      if (fifo_rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
      if (m_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(m_valid), 32'd0);
        else begin
          chk("m_data", 32'(m_data), 32'(exp_q[0]));
          chk("m_last", 32'(m_last), 32'(exp_beat == BEATS - 1));
        end
        chk("busy_in_send", 32'(busy), 32'd1);
      end
    end
    if (rst) begin
      exp_q.delete();
      exp_beat = 0;
      exp_cnt = 0;
    end else begin
      if (fifo_rd_en) begin
        rd_cyc.push_back(cyc);
        w = mem[rd_ptr[5:0]];
        for (int i = 0; i < BEATS; i++) begin
`ifdef FIFO_SER_MSB_FIRST_EN
          exp_q.push_back(w[DW-1-8*i -: 8]);
`else
          exp_q.push_back(w[8*i +: 8]);
`endif
        end
      end
      if (m_valid && m_ready) begin
        xfer_cyc.push_back(cyc);
        xfer_byte.push_back(m_data);
        $display("xfer cycle=%0d byte=%02h last=%0b", cyc, m_data, m_last);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_beat == BEATS - 1) begin
          exp_beat = 0;
          exp_cnt++;
          last_cyc.push_back(cyc);
        end else begin
          exp_beat++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (!busy && fifo_empty) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] lit [4];
    int t0, rb, xb, lb;
    bit seen;
`ifdef FIFO_SER_MSB_FIRST_EN
    lit = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
`else
    lit = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
`endif
    rst = 1'b1;
    m_ready = 1'b0;
    step(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    step(2);

    // Single word, consumer always ready: fixed latency and byte order.
    m_ready = 1'b1;
    rb = rd_cyc.size(); xb = xfer_cyc.size(); lb = last_cyc.size();
    t0 = cyc;
    push(32'hA1B2C3D4);
    step(7);
    chk("w1_rd_count", 32'(rd_cyc.size() - rb), 32'd1);
    if (rd_cyc.size() > rb) chk("w1_rd_latency", 32'(rd_cyc[rb]), 32'(t0 + 1));
    chk("w1_xfer_count", 32'(xfer_cyc.size() - xb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (xfer_cyc.size() > xb + i) begin
        chk("w1_byte", 32'(xfer_byte[xb+i]), 32'(lit[i]));
        chk("w1_byte_cycle", 32'(xfer_cyc[xb+i]), 32'(t0 + 3 + i));
      end
    end
    if (last_cyc.size() > lb) chk("w1_last_cycle", 32'(last_cyc[lb]), 32'(t0 + 6));
    chk("w1_busy", 32'(busy), 32'd0);
    chk("w1_valid", 32'(m_valid), 32'd0);
    chk("w1_word_cnt", 32'(word_cnt), 32'd1);

    // Backpressure on beat 1 for five cycles.
    m_ready = 1'b0;
    rb = rd_cyc.size(); xb = xfer_cyc.size();
    push(32'h11223344);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
`ifdef FIFO_SER_MSB_FIRST_EN
      chk("bp_hold_data", 32'(m_data), 32'h22);
`else
      chk("bp_hold_data", 32'(m_data), 32'h33);
`endif
      chk("bp_hold_valid", 32'(m_valid), 32'd1);
      step(1);
    end
    chk("bp_no_advance", 32'(xfer_cyc.size() - xb), 32'd1);
    chk("bp_no_extra_rd", 32'(rd_cyc.size() - rb), 32'd1);
    m_ready = 1'b1;
    wait_idle(20);
    chk("bp_word_cnt", 32'(word_cnt), 32'd2);

    // Three words back to back: each read follows the previous last beat immediately.
    rb = rd_cyc.size(); xb = xfer_cyc.size(); lb = last_cyc.size();
    t0 = cyc;
    push(32'h0A0B0C0D);
    push(32'h10203040);
    push(32'hDEADBEEF);
    wait_idle(60);
    chk("b2b_rd_count", 32'(rd_cyc.size() - rb), 32'd3);
    chk("b2b_xfer_count", 32'(xfer_cyc.size() - xb), 32'd12);
    chk("b2b_word_cnt", 32'(word_cnt), 32'd5);
    if (rd_cyc.size() >= rb + 3 && last_cyc.size() >= lb + 2) begin
      chk("b2b_first_rd", 32'(rd_cyc[rb]), 32'(t0 + 1));
      chk("b2b_gap1", 32'(rd_cyc[rb+1]), 32'(last_cyc[lb] + 1));
      chk("b2b_gap2", 32'(rd_cyc[rb+2]), 32'(last_cyc[lb+1] + 1));
    end
    if (xfer_byte.size() > xb + 4) begin
`ifdef FIFO_SER_MSB_FIRST_EN
      chk("b2b_word2_beat0", 32'(xfer_byte[xb+4]), 32'h10);
`else
      chk("b2b_word2_beat0", 32'(xfer_byte[xb+4]), 32'h40);
`endif
    end

    // Empty FIFO for 100 cycles with m_ready toggling.
    for (int k = 0; k < 100; k++) begin
      m_ready = k[0];
      step(1);
      chk("empty_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("empty_valid", 32'(m_valid), 32'd0);
      chk("empty_busy", 32'(busy), 32'd0);
    end

    // Reset after beat 2: the partial word is dropped and never re-read.
    m_ready = 1'b1;
    xb = xfer_cyc.size();
    push(32'hCAFEF00D);
    for (int k = 0; k < 20; k++) begin
      if (xfer_cyc.size() >= xb + 3) break;
      step(1);
    end
    chk("mid_xfers", 32'(xfer_cyc.size() - xb), 32'd3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reset_vals("midrst");
    rb = rd_cyc.size();
    step(5);
    chk("midrst_no_reread", 32'(rd_cyc.size() - rb), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    xb = xfer_cyc.size();
    push(32'h01020304);
    wait_idle(20);
    chk("post_rst_xfers", 32'(xfer_cyc.size() - xb), 32'd4);
    if (xfer_byte.size() > xb) begin
`ifdef FIFO_SER_MSB_FIRST_EN
      chk("post_rst_beat0", 32'(xfer_byte[xb]), 32'h01);
`else
      chk("post_rst_beat0", 32'(xfer_byte[xb]), 32'h04);
`endif
    end
    chk("post_rst_word_cnt", 32'(word_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_byte_serializer.md
FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the FIFO word width in bits; it SHALL be a multiple of 8 and at least 16.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the word counter.
REQ-003 clk  input  1  Sole clock; all state updates on rising edge.
REQ-004 rst  input  1  Reset; synchronous to clk and active-high.
REQ-005 fifo_empty  input  1  Empty flag from the upstream synchronous FIFO.
REQ-006 fifo_rd_en  output  1  Read request to the FIFO; the FIFO chip select is tied high at the integration level.
REQ-007 fifo_data  input  DATA_WIDTH  FIFO read data; valid on the cycle after fifo_rd_en is sampled high.
REQ-008 m_valid  output  1  Byte-stream valid.
REQ-009 m_ready  input  1  Byte-stream ready from the consumer.
REQ-010 m_data  output  8  Byte-stream data.
REQ-011 m_last  output  1  High with the final byte of each word.
REQ-012 busy  output  1  High in every state except IDLE.
REQ-013 word_cnt  output  CNT_WIDTH  Count of fully transmitted words.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, READ, CAPTURE and SEND.
REQ-015 In IDLE with fifo_empty=0, the FSM SHALL go to READ; otherwise it SHALL remain in IDLE.
REQ-016 fifo_rd_en SHALL be a registered output, high only while in READ, for exactly one cycle per word.
REQ-017 The FSM SHALL go from READ to CAPTURE unconditionally.
REQ-018 On the CAPTURE-to-SEND edge, the block SHALL latch fifo_data into a DATA_WIDTH shift register and load byte index 0.
REQ-019 In SEND, m_valid SHALL be 1; a byte SHALL transfer on any cycle with m_valid=1 and m_ready=1.
REQ-020 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-021 Bytes SHALL be sent in DATA_WIDTH/8 beats; the byte index SHALL advance only on a transfer; m_last=1 only on the beat with index DATA_WIDTH/8-1.
REQ-022 On transfer of the last byte, word_cnt SHALL increment by 1, wrapping modulo 2^CNT_WIDTH.
REQ-023 On that same transfer, the FSM SHALL go to READ if fifo_empty=0, else to IDLE, with no idle gap in the READ case.
REQ-024 Latency SHALL be fixed: fifo_empty falls in cycle N (FSM in IDLE) -> fifo_rd_en high in N+1 -> CAPTURE in N+2 -> first m_valid in N+3.
REQ-025 The block SHALL never assert fifo_rd_en while fifo_empty=1 is sampled in the deciding state.
REQ-026 The block SHALL hold at most one word in flight.
REQ-027 m_valid SHALL be 0 in IDLE, READ and CAPTURE.
REQ-028 m_ready SHALL be ignored outside SEND.
REQ-029 Changes on fifo_empty during READ, CAPTURE or SEND SHALL have no effect until the final-byte decision.
REQ-030 m_data, m_last and m_valid SHALL be driven directly from registers, with no combinational path from m_ready.

Reset
REQ-031 Reset SHALL take effect only on the next rising clk edge with rst=1.
REQ-032 On reset: state=IDLE, fifo_rd_en=0, m_valid=0, m_last=0, m_data=8'h00, busy=0, word_cnt=0, byte index=0, shift register=0.
REQ-033 Reset mid-word SHALL discard the partially sent word without incrementing word_cnt; the word is lost and is not re-read from the FIFO.
REQ-034 Reset SHALL take priority over every transfer or FSM decision in the same cycle.

Configuration
REQ-035 Macro FIFO_SER_MSB_FIRST_EN defined: bytes SHALL be sent most-significant first, fifo_data[DATA_WIDTH-1:DATA_WIDTH-8] on beat 0.
REQ-036 Macro FIFO_SER_MSB_FIRST_EN undefined: bytes SHALL be sent least-significant first, fifo_data[7:0] on beat 0.
REQ-037 Timing, handshake and counters SHALL be identical in both builds.

Verification
REQ-038 Single word, macro undefined, m_ready=1: FIFO holds 32'hA1B2C3D4 -> m_data D4,C3,B2,A1 on consecutive cycles, m_last on A1, word_cnt=1, then IDLE.
REQ-039 Macro defined, same word -> m_data A1,B2,C3,D4, m_last on D4.
REQ-040 Backpressure: m_ready held 0 for 5 cycles on beat 1 -> m_data stays constant, byte index does not advance, no extra fifo_rd_en.
REQ-041 Back-to-back: FIFO holds 3 words, m_ready=1 -> exactly 3 single-cycle fifo_rd_en pulses, each READ immediately after the last beat, 12 bytes sent, word_cnt=3.
REQ-042 Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_rd_en, m_valid and busy stay 0.
REQ-043 Reset mid-word: rst=1 after beat 2 -> next cycle all outputs at reset values, word_cnt=0; next FIFO word restarts at beat 0.
